// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with press/release debounce and one-cycle key_valid.
// Define KEYPAD_MULTIKEY_REJECT_EN to ignore samples with more than one row set.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic       key_busy
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] r1_q, rs_q, cap_row_q, cap_row_d, key_row_q, key_row_d, key_col_q, key_col_d;
  logic [1:0] ci_q, ci_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic key_valid_q, key_valid_d, key_busy_q, key_busy_d;
  logic dwell_end, cnt_end, take;
  logic [3:0] row_sel;
  assign col_out = 4'b0001 << ci_q;
  assign key_row = key_row_q;
  assign key_col = key_col_q;
  assign key_valid = key_valid_q;
  assign key_busy = key_busy_q;
  assign dwell_end = dwell_q == DW'(SCAN_DIV - 1);
  assign cnt_end = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign take = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
  assign row_sel = cap_row_q;
`else
  assign take = rs_q != 4'd0;
  assign row_sel = cap_row_q & (~cap_row_q + 4'd1);
`endif
  always_comb begin
    state_d = state_q;
    ci_d = ci_q;
    dwell_d = dwell_q;
    cnt_d = cnt_q;
    cap_row_d = cap_row_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    key_valid_d = 1'b0;
    key_busy_d = key_busy_q;
    case (state_q)
      SCAN:
        if (!dwell_end) dwell_d = dwell_q + DW'(1);
        else if (take) begin
          cap_row_d = rs_q;
          cnt_d = '0;
          state_d = DEBOUNCE;
        end else begin
          ci_d = ci_q + 2'd1;
          dwell_d = '0;
        end
      DEBOUNCE:
        if (rs_q != cap_row_q) begin
          state_d = SCAN;
          dwell_d = '0;
        end else if (cnt_end) begin
          state_d = HELD;
          key_row_d = row_sel;
          key_col_d = col_out;
          key_valid_d = 1'b1;
          key_busy_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      HELD:
        if (rs_q == 4'd0) begin
          cnt_d = '0;
          state_d = RELEASE;
        end
      RELEASE:
        if (rs_q != 4'd0) begin
          state_d = HELD;
          cnt_d = '0;
        end else if (cnt_end) begin
          state_d = SCAN;
          ci_d = ci_q + 2'd1;
          dwell_d = '0;
          key_busy_d = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q <= '0;
      rs_q <= '0;
      state_q <= SCAN;
      ci_q <= '0;
      dwell_q <= '0;
      cnt_q <= '0;
      cap_row_q <= '0;
      key_row_q <= '0;
      key_col_q <= '0;
      key_valid_q <= 1'b0;
      key_busy_q <= 1'b0;
    end else begin
      r1_q <= row_in;
      rs_q <= r1_q;
      state_q <= state_d;
      ci_q <= ci_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      cap_row_q <= cap_row_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      key_valid_q <= key_valid_d;
      key_busy_q <= key_busy_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad model plus arithmetic scan-timing prediction for keypad_scanner.
module tb_keypad_scanner;
  localparam int SD = 4, DB = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] row_in = 4'b0000, col_out, key_row, key_col;
  logic key_valid, key_busy;
  int checks = 0, failures = 0, cyc = 0, nvalid = 0, last_valid = -1, base_f = 0, base_b = 0;
  logic pressed = 1'b0;
  logic [3:0] prow = 4'b0000;
  logic [1:0] pcol = 2'd0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .key_row(key_row), .key_col(key_col), .key_valid(key_valid), .key_busy(key_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keypad: the pressed key's rows appear only while its column is driven.
  task automatic drive();
    row_in = (pressed && col_out == (4'b0001 << pcol)) ? prow : 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) begin
      nvalid++;
      last_valid = cyc;
    end
    drive();
  endtask

  // Idle scan since edge f starting at column b: column (b + j/SD)%4 after edge f+j.
  // A key pressed after edge e is seen at the first dwell-terminal edge whose column
  // was being driven when the key was already down three edges earlier.
  function automatic int predict(input int f, input int b, input int e, input int c);
    for (int m = 1; m < 64; m++)
      if (f + SD * m - 3 >= e && (b + m - 1) % 4 == c) return f + SD * m + DB;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    pressed = 1'b0;
    row_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col_out", col_out, 4'b0001);
    chk("rst_key_row", key_row, 4'b0000);
    chk("rst_key_col", key_col, 4'b0000);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_busy", key_busy, 1'b0);
    reset = 1'b0;
    cyc = 0;
    nvalid = 0;
    last_valid = -1;
    base_f = 0;
    base_b = 0;
  endtask

  task automatic release_chk(input logic [1:0] c, input string nm);
    int rel;
    logic [1:0] nc;
    nc = c + 2'd1;
    pressed = 1'b0;
    drive();
    rel = cyc;
    while (cyc < rel + 10) tick();
    chk({nm, "_busy_hold"}, key_busy, 1'b1);
    tick();
    chk({nm, "_busy_fall"}, key_busy, 1'b0);
    chk({nm, "_resume_col"}, col_out, 4'b0001 << nc);
    base_f = cyc;
    base_b = int'(nc);
  endtask

  task automatic key_cycle(input logic [3:0] r, input logic [1:0] c, input int delay, input int hold, input string nm);
    int pv, n0;
    repeat (delay) tick();
    n0 = nvalid;
    prow = r;
    pcol = c;
    pressed = 1'b1;
    drive();
    pv = predict(base_f, base_b, cyc, int'(c));
    while (cyc < pv + hold) tick();
    chk({nm, "_nvalid"}, nvalid - n0, 1);
    chk({nm, "_valid_cyc"}, last_valid, pv);
    chk({nm, "_key_row"}, key_row, r);
    chk({nm, "_key_col"}, key_col, 4'b0001 << c);
    chk({nm, "_busy"}, key_busy, 1'b1);
    release_chk(c, nm);
  endtask

  initial begin
    int pv, n0;
    logic busy_or, busy_and;
    logic [3:0] cols, r;
    logic [1:0] c;
    do_reset();
    // idle scan
    for (int k = 0; k < 20; k++) begin
      tick();
      cols = 4'b0001 << ((cyc / SD) % 4);
      chk("idle_col_out", col_out, cols);
    end
    chk("idle_no_valid", nvalid, 0);
    key_cycle(4'b0010, 2'd1, 0, 5, "key5");
    for (int i = 0; i < 5; i++) begin
      r = 4'b0001 << $urandom_range(0, 3);
      c = 2'($urandom_range(0, 3));
      key_cycle(r, c, int'($urandom_range(0, 12)), int'($urandom_range(1, 30)), "rand_key");
    end
    // bounce after capture
    prow = 4'b0100;
    pcol = 2'($urandom_range(0, 3));
    pressed = 1'b1;
    drive();
    pv = predict(base_f, base_b, cyc, int'(pcol));
    while (cyc < pv - DB) tick();
    n0 = nvalid;
    busy_or = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) begin
        pressed = !pressed;
        drive();
      end
      tick();
      busy_or |= key_busy;
    end
    pressed = 1'b0;
    drive();
    repeat (12) tick();
    cols = 4'b0000;
    repeat (4 * SD) begin
      tick();
      cols |= col_out;
    end
    chk("bounce_no_valid", nvalid - n0, 0);
    chk("bounce_busy", busy_or, 1'b0);
    chk("bounce_scan_cols", cols, 4'hF);
    // long hold of "A" with a short release glitch
    do_reset();
    prow = 4'b0001;
    pcol = 2'd3;
    pressed = 1'b1;
    drive();
    pv = predict(0, 0, 0, 3);
    while (cyc < pv) tick();
    busy_and = 1'b1;
    while (cyc < 100) begin
      tick();
      busy_and &= key_busy;
    end
    pressed = 1'b0;
    drive();
    repeat (3) begin
      tick();
      busy_and &= key_busy;
    end
    pressed = 1'b1;
    drive();
    while (cyc < pv + 200) begin
      tick();
      busy_and &= key_busy;
    end
    chk("holdA_nvalid", nvalid, 1);
    chk("holdA_valid_cyc", last_valid, pv);
    chk("holdA_busy_glitch", busy_and, 1'b1);
    chk("holdA_key_row", key_row, 4'b0001);
    chk("holdA_key_col", key_col, 4'b1000);
    release_chk(2'd3, "holdA");
    // two rows on column 0
    do_reset();
    prow = 4'b0011;
    pcol = 2'd0;
    pressed = 1'b1;
    drive();
    pv = predict(0, 0, 0, 0);
    while (cyc < pv + 3) tick();
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    chk("multi_nvalid", nvalid, 0);
    chk("multi_busy", key_busy, 1'b0);
    pressed = 1'b0;
    drive();
`else
    chk("multi_nvalid", nvalid, 1);
    chk("multi_valid_cyc", last_valid, pv);
    chk("multi_key_row", key_row, 4'b0001);
    chk("multi_key_col", key_col, 4'b0001);
    release_chk(2'd0, "multi");
`endif
    // asynchronous reset while held
    do_reset();
    prow = 4'b0001 << $urandom_range(0, 3);
    pcol = 2'($urandom_range(0, 3));
    pressed = 1'b1;
    drive();
    pv = predict(0, 0, 0, int'(pcol));
    while (cyc < pv + 5) tick();
    chk("held_pre_busy", key_busy, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("async_col_out", col_out, 4'b0001);
    chk("async_busy", key_busy, 1'b0);
    chk("async_key_row", key_row, 4'b0000);
    chk("async_key_col", key_col, 4'b0000);
    chk("async_valid", key_valid, 1'b0);
    pressed = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    n0 = nvalid;
    repeat (40) tick();
    chk("post_rst_no_valid", nvalid - n0, 0);
    chk("post_rst_busy", key_busy, 1'b0);
    chk("post_rst_key_row", key_row, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
